// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the 'sub' input.
//   chunk_w()       : bits resolved per pipeline stage.
//   stage_rec_t     : stage record layout (valid, carry, carry into chunk MSB,
//                     partial sum, remaining operand bits) at the default
//                     32-bit width. The RTL uses the same field order sized to
//                     its own WIDTH parameter.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int REC_WIDTH = 32;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 cmsb;
        logic [REC_WIDTH-1:0] psum;
        logic [REC_WIDTH-1:0] a_rem;
        logic [REC_WIDTH-1:0] b_rem;
    } stage_rec_t;

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: purely combinational CW-bit ripple of full-adder cells.
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   s     : chunk sum
//   cout  : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (used for signed overflow on the top chunk)
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar j = 0; j < CW; j++) begin : g_fa
        assign s[j]   = a[j] ^ b[j] ^ c[j];
        assign c[j+1] = (a[j] & b[j]) | ((a[j] ^ b[j]) & c[j]);
    end

    assign cout = c[CW];
    assign cmsb = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep pipelined two's-complement add/subtract.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : input beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum  : a+b+cin or a-b, modulo 2^WIDTH
//   cout : carry out of MSB (for subtract, 1 = no borrow)
//   ovf  : signed overflow
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; the sender holds its beat stable until then. The whole pipeline moves
// together: it advances when the output slot is empty or being consumed, and
// in_ready is exactly that advance condition.
// Stage register i holds the result of chunk i, the carry out of that chunk,
// all lower sum chunks already resolved, and the operands (b pre-inverted for
// subtract) so that upper chunks are available to later stages.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = chunk_w(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             cmsb;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    stage_t st [STAGES];
    stage_t nx [STAGES];

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign bx = (sub == OP_SUB) ? ~b : b;
    assign c0 = (sub == OP_SUB) ? 1'b1 : cin;

    assign out_valid = st[STAGES-1].valid;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [C-1:0]     ca;
        logic [C-1:0]     cb;
        logic [C-1:0]     cs;
        logic             ci;
        logic             co;
        logic             cm;
        logic             vld;
        logic [WIDTH-1:0] ps_in;
        logic [WIDTH-1:0] ps;
        logic [WIDTH-1:0] ar;
        logic [WIDTH-1:0] br;

        if (i == 0) begin : g_first
            assign ca    = a[C-1:0];
            assign cb    = bx[C-1:0];
            assign ci    = c0;
            assign vld   = in_valid;
            assign ps_in = '0;
            assign ar    = a;
            assign br    = bx;
        end else begin : g_next
            assign ca    = st[i-1].a_rem[i*C +: C];
            assign cb    = st[i-1].b_rem[i*C +: C];
            assign ci    = st[i-1].carry;
            assign vld   = st[i-1].valid;
            assign ps_in = st[i-1].psum;
            assign ar    = st[i-1].a_rem;
            assign br    = st[i-1].b_rem;
        end

        adder_chunk #(.CW(C)) u_chunk (
            .a    (ca),
            .b    (cb),
            .cin  (ci),
            .s    (cs),
            .cout (co),
            .cmsb (cm)
        );

        always_comb begin
            ps          = ps_in;
            ps[i*C +: C] = cs;
        end

        assign nx[i] = '{valid: vld, carry: co, cmsb: cm, psum: ps, a_rem: ar, b_rem: br};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                st[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                st[i] <= nx[i];
            end
        end
    end

    assign sum  = st[STAGES-1].psum;
    assign cout = st[STAGES-1].carry;
    assign ovf  = st[STAGES-1].cmsb ^ st[STAGES-1].carry;

endmodule
